// File: rtl/iexecute_pipe.sv
// -----------------------------------------------------------------------------
// iexecute_pipe : registered LEGv8 execute stage
//
// Purpose
//   Selects operand B, evaluates ADD/SUB/AND/ORR/pass-B in one cycle or MUL
//   by an iterative shift-add multiplier (one multiplier bit per cycle). It
//   also forms the branch target pc_in + (sign_extend << BR_SHIFT). The
//   result, zero flag and branch target sit in a single-entry output
//   register. Both sides use valid/ready handshakes.
//
// Parameters
//   WORD      datapath width (>= 8, even)
//   BR_SHIFT  left shift applied to sign_extend for branch_target
//
// Ports
//   clk            in   clock, all state updates on the rising edge
//   reset_n        in   synchronous reset, active-low
//   in_valid       in   decode presents an instruction
//   in_ready       out  stage accepts this cycle
//   pc_in          in   PC of the instruction
//   read_data1     in   operand A
//   read_data2     in   register operand B
//   sign_extend    in   sign-extended immediate
//   opcode         in   instruction[31:21]
//   alu_op         in   00 ADD, 01 pass-B (CBZ), 10 R-type by opcode, 11 as 00
//   alu_src        in   1: B = sign_extend, 0: B = read_data2
//   out_valid      out  output registers hold a valid result
//   out_ready      in   memory stage consumes the result
//   alu_result     out  registered result
//   zero           out  registered (alu_result == 0)
//   branch_target  out  registered branch target
//   busy           out  high while a MUL iterates
//   flags          out  {N,Z,C,V}, only when EXEC_FLAGS_EN is defined
//
// Configuration macro
//   EXEC_FLAGS_EN  adds the registered flags output and its logic
// -----------------------------------------------------------------------------
module iexecute_pipe #(
   parameter int unsigned WORD     = 64,
   parameter int unsigned BR_SHIFT = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [WORD-1:0] pc_in,
   input  logic [WORD-1:0] read_data1,
   input  logic [WORD-1:0] read_data2,
   input  logic [WORD-1:0] sign_extend,
   input  logic [10:0]     opcode,
   input  logic [1:0]      alu_op,
   input  logic            alu_src,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [WORD-1:0] alu_result,
   output logic            zero,
   output logic [WORD-1:0] branch_target,
   output logic            busy
`ifdef EXEC_FLAGS_EN
  ,output logic [3:0]      flags
`endif
);

   localparam int unsigned CNT_W = $clog2(WORD);

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_MUL_BUSY = 1'b1;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_ORR  = 3'd3;
   localparam logic [2:0] OP_PASS = 3'd4;
   localparam logic [2:0] OP_MUL  = 3'd5;
   localparam logic [2:0] OP_NONE = 3'd6;

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;
   localparam logic [10:0] OPC_MUL = 11'b10011011000;

   // ---------------------------------------------------------------- state
   logic [0:0]      state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WORD-1:0] mul_a_q,   mul_a_d;
   logic [WORD-1:0] mul_b_q,   mul_b_d;
   logic [WORD-1:0] acc_q,     acc_d;
   logic [WORD-1:0] pend_bt_q, pend_bt_d;
   logic            out_valid_q, out_valid_d;
   logic [WORD-1:0] result_q,  result_d;
   logic            zero_q,    zero_d;
   logic [WORD-1:0] bt_q,      bt_d;
`ifdef EXEC_FLAGS_EN
   logic [3:0]      flags_q,   flags_d;
`endif

   // ---------------------------------------------------------------- decode
   logic [2:0]      op_sel;
   logic [WORD-1:0] opb;
   logic [WORD-1:0] bt_calc;
   logic            accept;
   logic            mul_start;
   logic            mul_done;
   logic [WORD-1:0] mul_acc_next;

   always_comb begin
      op_sel = OP_ADD;
      case (alu_op)
         2'b01: op_sel = OP_PASS;
         2'b10: begin
            case (opcode)
               OPC_ADD: op_sel = OP_ADD;
               OPC_SUB: op_sel = OP_SUB;
               OPC_AND: op_sel = OP_AND;
               OPC_ORR: op_sel = OP_ORR;
               OPC_MUL: op_sel = OP_MUL;
               default: op_sel = OP_NONE;
            endcase
         end
         default: op_sel = OP_ADD;
      endcase
   end

   assign opb     = alu_src ? sign_extend : read_data2;
   assign bt_calc = pc_in + (sign_extend << BR_SHIFT);

   assign in_ready  = reset_n & (state_q == ST_IDLE) & (~out_valid_q | out_ready);
   assign accept    = in_valid & in_ready;
   assign mul_start = accept & (op_sel == OP_MUL);
   assign mul_done  = (state_q == ST_MUL_BUSY) && (cnt_q == CNT_W'(WORD - 1));

   // One multiplier bit per cycle: add the shifted multiplicand when the
   // current low bit of the multiplier is set. Only the low WORD bits of the
   // product are ever needed, so the accumulator stays WORD wide.
   assign mul_acc_next = acc_q + (mul_b_q[0] ? mul_a_q : '0);

   // ---------------------------------------------------------------- ALU
   logic [WORD-1:0] add_sum;
   logic [WORD-1:0] sub_diff;
   logic [WORD-1:0] alu_res;

`ifdef EXEC_FLAGS_EN
   logic [WORD:0]   add_w;
   logic [WORD:0]   sub_w;
   logic            add_v;
   logic            sub_v;
   logic            fl_c;
   logic            fl_v;

   // SUB is a + ~b + 1 so the carry out is the ARM no-borrow flag.
   assign add_w    = {1'b0, read_data1} + {1'b0, opb};
   assign sub_w    = {1'b0, read_data1} + {1'b0, ~opb} + {{WORD{1'b0}}, 1'b1};
   assign add_sum  = add_w[WORD-1:0];
   assign sub_diff = sub_w[WORD-1:0];
   assign add_v    = (read_data1[WORD-1] == opb[WORD-1]) &
                     (add_sum[WORD-1] != read_data1[WORD-1]);
   assign sub_v    = (read_data1[WORD-1] != opb[WORD-1]) &
                     (sub_diff[WORD-1] != read_data1[WORD-1]);
`else
   assign add_sum  = read_data1 + opb;
   assign sub_diff = read_data1 - opb;
`endif

   always_comb begin
      alu_res = '0;
`ifdef EXEC_FLAGS_EN
      fl_c = 1'b0;
      fl_v = 1'b0;
`endif
      case (op_sel)
         OP_ADD: begin
            alu_res = add_sum;
`ifdef EXEC_FLAGS_EN
            fl_c = add_w[WORD];
            fl_v = add_v;
`endif
         end
         OP_SUB: begin
            alu_res = sub_diff;
`ifdef EXEC_FLAGS_EN
            fl_c = sub_w[WORD];
            fl_v = sub_v;
`endif
         end
         OP_AND:  alu_res = read_data1 & opb;
         OP_ORR:  alu_res = read_data1 | opb;
         OP_PASS: alu_res = opb;
         default: alu_res = '0;
      endcase
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      acc_d       = acc_q;
      pend_bt_d   = pend_bt_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      bt_d        = bt_q;
`ifdef EXEC_FLAGS_EN
      flags_d     = flags_q;
`endif

      // multiplier sequencing
      case (state_q)
         ST_IDLE: begin
            if (mul_start) begin
               state_d   = ST_MUL_BUSY;
               cnt_d     = '0;
               mul_a_d   = read_data1;
               mul_b_d   = opb;
               acc_d     = '0;
               pend_bt_d = bt_calc;
            end
         end
         default: begin
            acc_d   = mul_acc_next;
            mul_a_d = mul_a_q << 1;
            mul_b_d = mul_b_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (mul_done) begin
               state_d = ST_IDLE;
            end
         end
      endcase

      // Output register. An accept only happens when the register is empty
      // or retiring, so a held result is never overwritten. A MUL start
      // retires the old result and leaves the register empty until the
      // product is ready.
      if (accept && !mul_start) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         zero_d      = (alu_res == '0);
         bt_d        = bt_calc;
`ifdef EXEC_FLAGS_EN
         flags_d     = {alu_res[WORD-1], (alu_res == '0), fl_c, fl_v};
`endif
      end else if (mul_start) begin
         out_valid_d = 1'b0;
      end else if (mul_done) begin
         out_valid_d = 1'b1;
         result_d    = mul_acc_next;
         zero_d      = (mul_acc_next == '0);
         bt_d        = pend_bt_q;
`ifdef EXEC_FLAGS_EN
         flags_d     = {mul_acc_next[WORD-1], (mul_acc_next == '0), 2'b00};
`endif
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         acc_q       <= '0;
         pend_bt_q   <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         bt_q        <= '0;
`ifdef EXEC_FLAGS_EN
         flags_q     <= 4'b0000;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         acc_q       <= acc_d;
         pend_bt_q   <= pend_bt_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         bt_q        <= bt_d;
`ifdef EXEC_FLAGS_EN
         flags_q     <= flags_d;
`endif
      end
   end

   assign out_valid     = out_valid_q;
   assign alu_result    = result_q;
   assign zero          = zero_q;
   assign branch_target = bt_q;
   assign busy          = (state_q == ST_MUL_BUSY);
`ifdef EXEC_FLAGS_EN
   assign flags         = flags_q;
`endif

endmodule
